// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter with bounded hold time for one shared resource.
// It issues a registered one-hot grant and adds one dead cycle between tenures.
module rr_grant_scheduler #(
  parameter int N_REQ    = 5,
  parameter int MAX_HOLD = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;
  int                arb_sum;
  logic              cur_done, cur_req, at_max;

  // Search begins just after the last grantee and wraps around, so a lone requester can win again.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    arb_sum   = 0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_sum = int'(last_id_q) + 1 + i;
      if (arb_sum >= N_REQ) arb_sum = arb_sum - N_REQ;
      cand = arb_sum[ID_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    last_id_d     = last_id_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_err_d = 1'b0;
    cur_done      = done[grant_id_q];
    cur_req       = req[grant_id_q];
    at_max        = (hold_cnt_q == HOLD_W'(MAX_HOLD));

    case (state_q)
      GRANT: begin
        if (cur_done || !cur_req || at_max) begin
          state_d       = RELEASE;
          grant_d       = '0;
          grant_id_d    = '0;
          hold_cnt_d    = '0;
          // Done and request drop take precedence over the hold limit.
          timeout_err_d = at_max && !cur_done && cur_req;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        hold_cnt_d = '0;
        grant_d    = '0;
        grant_id_d = '0;
        state_d    = IDLE;
        if (win_found) begin
          state_d         = GRANT;
          grant_d[win_id] = 1'b1;
          grant_id_d      = win_id;
          last_id_d       = win_id;
          hold_cnt_d      = HOLD_W'(1);
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      last_id_q     <= ID_W'(N_REQ - 1);
      hold_cnt_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      last_id_q     <= last_id_d;
      hold_cnt_q    <= hold_cnt_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler: directed vector tables, hand-built
// sequences for rotation, fairness and reset, then random traffic checked against a reference model.
module tb_rr_grant_scheduler;

  localparam int N   = 5;
  localparam int MH  = 6;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout_err;

  int vecCount  = 0;
  int missCount = 0;

  int mOwner;
  int mHeld;
  int mPtr;
  bit mDead;
  bit mTo;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] expGrant;
    logic         expTo;
    logic         expBusy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_grant_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  function automatic int idOf(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic checkOutput(string name, logic [N-1:0] expGrant, logic expTo, logic expBusy);
    vecCount++;
    if (grant !== expGrant || grant_valid !== (|expGrant) || grant_id !== IDW'(idOf(expGrant)) ||
        busy !== expBusy || timeout_err !== expTo) begin
      missCount++;
      $display("[TB] FAIL %s: got grant=%b valid=%b id=%0d busy=%b to=%b, want grant=%b valid=%b id=%0d busy=%b to=%b",
               name, grant, grant_valid, grant_id, busy, timeout_err,
               expGrant, |expGrant, idOf(expGrant), expBusy, expTo);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mHeld  = 0;
    mPtr   = N - 1;
    mDead  = 0;
    mTo    = 0;
  endtask

  // Reference behaviour: owner index, tenure length, and a round-robin pointer.
  task automatic modelStep(logic [N-1:0] r, logic [N-1:0] d);
    mTo = 0;
    if (mOwner >= 0) begin
      if (d[mOwner] || !r[mOwner] || mHeld == MH) begin
        mTo    = (mHeld == MH) && !d[mOwner] && r[mOwner];
        mOwner = -1;
        mDead  = 1;
        mHeld  = 0;
      end else begin
        mHeld++;
      end
    end else begin
      mDead = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mPtr + k) % N;
        if (r[c]) begin
          mOwner = c;
          mPtr   = c;
          mHeld  = 1;
          break;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] modelGrant();
    logic [N-1:0] g;
    g = '0;
    if (mOwner >= 0) g[mOwner] = 1'b1;
    return g;
  endfunction

  task automatic applyStimulus(logic [N-1:0] r, logic [N-1:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    modelStep(r, d);
    #1;
  endtask

  task automatic doReset();
    rst  = 1'b1;
    req  = '0;
    done = '0;
    @(posedge clk);
    #1;
    checkOutput("reset", '0, 1'b0, 1'b0);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = '0;
    modelReset();

    // Timeout on a lone requester, then a release by request drop.
    for (int i = 0; i < 6; i++) tbl.push_back('{5'b00100, 5'b00000, 5'b00100, 1'b0, 1'b1});
    tbl.push_back('{5'b00100, 5'b00000, 5'b00000, 1'b1, 1'b1});
    tbl.push_back('{5'b00100, 5'b00000, 5'b00100, 1'b0, 1'b1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0});
    // done arriving in the 6th grant cycle suppresses timeout_err.
    for (int i = 0; i < 6; i++) tbl.push_back('{5'b00010, 5'b00000, 5'b00010, 1'b0, 1'b1});
    tbl.push_back('{5'b00010, 5'b00010, 5'b00000, 1'b0, 1'b1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0});
    // Non-grantee done is ignored; a grantee request drop releases early.
    tbl.push_back('{5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b1});
    tbl.push_back('{5'b00001, 5'b00010, 5'b00001, 1'b0, 1'b1});
    tbl.push_back('{5'b00010, 5'b00000, 5'b00000, 1'b0, 1'b1});
    tbl.push_back('{5'b00010, 5'b00000, 5'b00010, 1'b0, 1'b1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0});

    doReset();
    for (int v = 0; v < tbl.size(); v++) begin
      applyStimulus(tbl[v].req, tbl[v].done);
      checkOutput($sformatf("table[%0d]", v), tbl[v].expGrant, tbl[v].expTo, tbl[v].expBusy);
    end

    // Rotation: each grantee pulses done in its second grant cycle.
    doReset();
    for (int m = 0; m < N; m++) begin
      logic [N-1:0] bitM;
      bitM = '0;
      bitM[m] = 1'b1;
      applyStimulus('1, '0);
      checkOutput($sformatf("rot%0d_first", m), bitM, 1'b0, 1'b1);
      applyStimulus('1, '0);
      checkOutput($sformatf("rot%0d_second", m), bitM, 1'b0, 1'b1);
      applyStimulus('1, bitM);
      checkOutput($sformatf("rot%0d_release", m), '0, 1'b0, 1'b1);
    end
    applyStimulus('1, '0);
    checkOutput("rot_wrap", 5'b00001, 1'b0, 1'b1);

    // Fairness: all request, nobody releases; tenures of 6 separated by one timeout cycle.
    doReset();
    for (int c = 1; c <= 29; c++) begin
      int slot;
      int pos;
      logic [N-1:0] g;
      slot = (c - 1) / (MH + 1);
      pos  = (c - 1) % (MH + 1);
      g    = '0;
      if (pos < MH) g[slot] = 1'b1;
      applyStimulus('1, '0);
      checkOutput($sformatf("fair_c%0d", c), g, (pos == MH), 1'b1);
    end

    // Reset asserted mid-tenure clears outputs without waiting for a clock.
    doReset();
    applyStimulus(5'b00100, '0);
    checkOutput("pre_midreset", 5'b00100, 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1 checkOutput("midreset_async", '0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    applyStimulus(5'b00001, '0);
    checkOutput("after_reset_m0", 5'b00001, 1'b0, 1'b1);

    // Random traffic with sticky requests so tenures regularly reach the hold limit.
    doReset();
    begin
      logic [N-1:0] r;
      logic [N-1:0] d;
      r = '0;
      for (int c = 0; c < 3000; c++) begin
        d = '0;
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(7) == 0) r[b] = ~r[b];
          if ($urandom_range(9) == 0) d[b] = 1'b1;
        end
        applyStimulus(r, d);
        checkOutput($sformatf("rand_c%0d", c), modelGrant(), mTo, (mOwner >= 0) || mDead);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
